// File: rtl/apb_protocol_monitor_pkg.sv
// Shared types for the APB protocol monitor: rule codes, FSM states and
// the priority encoder used for first-error capture.
package apb_protocol_monitor_pkg;

  localparam int APB_MON_RULES = 8;

  typedef enum logic [2:0] {
    APB_PSEL_DROP  = 3'd0,
    APB_PSEL_MULTI = 3'd1,
    APB_PEN_SETUP  = 3'd2,
    APB_PEN_ACCESS = 3'd3,
    APB_UNSTABLE   = 3'd4,
    APB_RD_STRB    = 3'd5,
    APB_WATCHDOG   = 3'd6,
    APB_PEN_IDLE   = 3'd7
  } apb_mon_rule_t;

  typedef enum logic {
    APB_MON_IDLE   = 1'b0,
    APB_MON_ACCESS = 1'b1
  } apb_mon_state_t;

  // Lowest set index wins when several rules fire in the same cycle.
  function automatic apb_mon_rule_t first_rule(input logic [APB_MON_RULES-1:0] hits);
    first_rule = APB_PSEL_DROP;
    for (int i = APB_MON_RULES - 1; i >= 0; i--) begin
      if (hits[i]) first_rule = apb_mon_rule_t'(i[2:0]);
    end
  endfunction

endpackage

// File: rtl/apb_protocol_monitor_if.sv
// APB3/APB4 bus bundle; the monitor uses the all-input monitor modport.
interface apb_protocol_monitor_if #(
  parameter int NUM_PSEL   = 4,
  parameter int PADDR_SIZE = 32,
  parameter int PDATA_SIZE = 32
);
  logic [NUM_PSEL-1:0]     PSEL;
  logic                    PENABLE;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic                    PWRITE;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PSTRB, PPROT, PWDATA,
    input  PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PSTRB, PPROT, PWDATA,
    output PREADY, PSLVERR
  );

  modport monitor (
    input PSEL, PENABLE, PADDR, PWRITE, PSTRB, PPROT, PWDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_protocol_monitor_watchdog.sv
// Wait-state counter: counts enabled cycles, pulses tc_o on the cycle the
// count reaches TIMEOUT, then holds there until cleared.
module apb_monitor_watchdog #(
  parameter int TIMEOUT = 128
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tc_o  = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
      tc_o  = (cnt_q == CW'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB3/APB4 protocol monitor: per-rule sticky flags, saturating
// counters, first-error capture and a registered interrupt.
//   state      | meaning
//   IDLE       | expecting no transfer or a setup cycle (|PSEL)
//   ACCESS     | inside access phase, waiting for PREADY
module apb_protocol_monitor
  import apb_protocol_monitor_pkg::*;
#(
  parameter int         NUM_PSEL         = 4,
  parameter int         PADDR_SIZE       = 32,
  parameter int         PDATA_SIZE       = 32,
  parameter bit         CHECK_PSTRB      = 1'b1,
  parameter bit         CHECK_PPROT      = 1'b1,
  parameter int         WATCHDOG_TIMEOUT = 128,
  parameter int         CNT_SIZE         = 16,
  parameter logic [7:0] IRQ_MASK         = 8'hFF
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_protocol_monitor_if.monitor bus,
  input  logic                  clr,
  output logic [7:0]            err_flags,
  output logic [CNT_SIZE-1:0]   err_cnt,
  output logic [CNT_SIZE-1:0]   xfer_cnt,
  output logic [CNT_SIZE-1:0]   slverr_cnt,
  output logic [2:0]            first_err_code,
  output logic [PADDR_SIZE-1:0] first_err_addr,
  output logic                  first_err_valid,
  output logic                  irq
);
  localparam int STRB_SIZE = PDATA_SIZE / 8;

  apb_mon_state_t state_q, state_d;

  logic [NUM_PSEL-1:0]   psel_q;
  logic [PADDR_SIZE-1:0] addr_q;
  logic                  write_q;
  logic [STRB_SIZE-1:0]  strb_q;
  logic [2:0]            prot_q;
  logic [PDATA_SIZE-1:0] wdata_q;

  logic [APB_MON_RULES-1:0] flags_q, flags_d, hit;
  logic [CNT_SIZE-1:0]      err_cnt_q, err_cnt_d;
  logic [CNT_SIZE-1:0]      xfer_cnt_q, xfer_cnt_d;
  logic [CNT_SIZE-1:0]      slverr_cnt_q, slverr_cnt_d;
  logic [2:0]               code_q, code_d;
  logic [PADDR_SIZE-1:0]    faddr_q, faddr_d;
  logic                     fvalid_q, fvalid_d;
  logic                     irq_q, irq_d;

  logic in_setup, in_access, xfer_done, wd_tc;

  function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v,
                                                  input logic inc);
    return (inc && (v != '1)) ? v + CNT_SIZE'(1) : v;
  endfunction

  assign in_setup  = (state_q == APB_MON_IDLE) && (|bus.PSEL);
  assign in_access = (state_q == APB_MON_ACCESS);
  assign xfer_done = in_access && bus.PENABLE && bus.PREADY;

  generate
    if (WATCHDOG_TIMEOUT != 0) begin : g_wd
      apb_monitor_watchdog #(.TIMEOUT(WATCHDOG_TIMEOUT)) u_wd (
        .clk_i (PCLK),
        .rst_i (PRESET),
        .clr_i (state_q == APB_MON_IDLE),
        .en_i  (in_access && !bus.PREADY),
        .tc_o  (wd_tc)
      );
    end else begin : g_no_wd
      assign wd_tc = 1'b0;
    end
  endgenerate

  always_comb begin
    hit = '0;
    hit[APB_PSEL_DROP]  = in_access && (bus.PSEL != psel_q);
    hit[APB_PSEL_MULTI] = ($countones(bus.PSEL) > 1);
    hit[APB_PEN_SETUP]  = in_setup && bus.PENABLE;
    hit[APB_PEN_ACCESS] = in_access && !bus.PENABLE;
    hit[APB_UNSTABLE]   = in_access &&
                          ((bus.PADDR != addr_q) || (bus.PWRITE != write_q) ||
                           (write_q && (bus.PWDATA != wdata_q)) ||
                           (CHECK_PSTRB && (bus.PSTRB != strb_q)) ||
                           (CHECK_PPROT && (bus.PPROT != prot_q)));
    hit[APB_RD_STRB]    = CHECK_PSTRB && in_setup && !bus.PWRITE && (bus.PSTRB != '0);
    hit[APB_WATCHDOG]   = wd_tc;
    hit[APB_PEN_IDLE]   = bus.PENABLE && (bus.PSEL == '0);
  end

  // A dropped PSEL aborts the transfer so it cannot cascade into more errors.
  always_comb begin
    state_d = state_q;
    case (state_q)
      APB_MON_IDLE:   if (|bus.PSEL) state_d = APB_MON_ACCESS;
      APB_MON_ACCESS: if (hit[APB_PSEL_DROP] || bus.PREADY) state_d = APB_MON_IDLE;
      default:        state_d = APB_MON_IDLE;
    endcase
  end

  // clr and a new violation in the same cycle: clear first, then set.
  always_comb begin
    flags_d      = (clr ? '0 : flags_q) | hit;
    err_cnt_d    = sat_inc(clr ? '0 : err_cnt_q, |hit);
    xfer_cnt_d   = sat_inc(clr ? '0 : xfer_cnt_q, xfer_done);
    slverr_cnt_d = sat_inc(clr ? '0 : slverr_cnt_q, xfer_done && bus.PSLVERR);
    fvalid_d     = clr ? 1'b0 : fvalid_q;
    code_d       = clr ? 3'd0 : code_q;
    faddr_d      = clr ? '0 : faddr_q;
    if (!fvalid_d && (|hit)) begin
      fvalid_d = 1'b1;
      code_d   = first_rule(hit);
      faddr_d  = bus.PADDR;
    end
    irq_d = |(flags_d & IRQ_MASK);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= APB_MON_IDLE;
      psel_q       <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      strb_q       <= '0;
      prot_q       <= '0;
      wdata_q      <= '0;
      flags_q      <= '0;
      err_cnt_q    <= '0;
      xfer_cnt_q   <= '0;
      slverr_cnt_q <= '0;
      code_q       <= '0;
      faddr_q      <= '0;
      fvalid_q     <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_setup) begin
        psel_q  <= bus.PSEL;
        addr_q  <= bus.PADDR;
        write_q <= bus.PWRITE;
        strb_q  <= bus.PSTRB;
        prot_q  <= bus.PPROT;
        wdata_q <= bus.PWDATA;
      end
      flags_q      <= flags_d;
      err_cnt_q    <= err_cnt_d;
      xfer_cnt_q   <= xfer_cnt_d;
      slverr_cnt_q <= slverr_cnt_d;
      code_q       <= code_d;
      faddr_q      <= faddr_d;
      fvalid_q     <= fvalid_d;
      irq_q        <= irq_d;
    end
  end

  assign err_flags       = flags_q;
  assign err_cnt         = err_cnt_q;
  assign xfer_cnt        = xfer_cnt_q;
  assign slverr_cnt      = slverr_cnt_q;
  assign first_err_code  = code_q;
  assign first_err_addr  = faddr_q;
  assign first_err_valid = fvalid_q;
  assign irq             = irq_q;
endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Directed bench for apb_protocol_monitor (WATCHDOG_TIMEOUT=8, CNT_SIZE=4).
module tb_apb_protocol_monitor;
  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       clr;
  logic [7:0] err_flags;
  logic [3:0] err_cnt, xfer_cnt, slverr_cnt;
  logic [2:0] first_err_code;
  logic [31:0] first_err_addr;
  logic       first_err_valid, irq;

  int n_chk  = 0;
  int n_fail = 0;

  apb_protocol_monitor_if #(.NUM_PSEL(4), .PADDR_SIZE(32), .PDATA_SIZE(32)) bus ();

  apb_protocol_monitor #(
    .NUM_PSEL(4), .PADDR_SIZE(32), .PDATA_SIZE(32), .CHECK_PSTRB(1'b1),
    .CHECK_PPROT(1'b1), .WATCHDOG_TIMEOUT(8), .CNT_SIZE(4), .IRQ_MASK(8'hFF)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus), .clr(clr),
    .err_flags(err_flags), .err_cnt(err_cnt), .xfer_cnt(xfer_cnt),
    .slverr_cnt(slverr_cnt), .first_err_code(first_err_code),
    .first_err_addr(first_err_addr), .first_err_valid(first_err_valid), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one bus cycle, then sample #1 after the edge that registered it.
  task automatic cyc(input logic [3:0] sel, input logic en, input logic [31:0] addr,
                     input logic wr, input logic [3:0] strb, input logic [31:0] wdata,
                     input logic rdy, input logic slverr);
    bus.PSEL    = sel;
    bus.PENABLE = en;
    bus.PADDR   = addr;
    bus.PWRITE  = wr;
    bus.PSTRB   = strb;
    bus.PWDATA  = wdata;
    bus.PREADY  = rdy;
    bus.PSLVERR = slverr;
    @(posedge PCLK);
    #1;
    clr = 1'b0;
  endtask

  task automatic idle();
    cyc(4'b0000, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.PPROT = 3'b000;
    clr       = 1'b0;
    PRESET    = 1'b1;
    idle();
    idle();
    chk("rst_flags", err_flags, 8'h00);
    chk("rst_errcnt", err_cnt, 4'd0);
    chk("rst_valid", first_err_valid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    PRESET = 1'b0;
    idle();

    // Legal write (0 waits) then back-to-back read (3 waits)
    cyc(4'b0010, 1'b0, 32'h10, 1'b1, 4'hF, 32'hA5, 1'b0, 1'b0);
    cyc(4'b0010, 1'b1, 32'h10, 1'b1, 4'hF, 32'hA5, 1'b1, 1'b0);
    cyc(4'b0010, 1'b0, 32'h20, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b0010, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    cyc(4'b0010, 1'b1, 32'h20, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    idle();
    chk("legal_flags", err_flags, 8'h00);
    chk("legal_xfer", xfer_cnt, 4'd2);
    chk("legal_irq", irq, 1'b0);
    chk("legal_errcnt", err_cnt, 4'd0);

    // PADDR changes during a wait state
    cyc(4'b0001, 1'b0, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    cyc(4'b0001, 1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    chk("unst_pre_flags", err_flags, 8'h00);
    cyc(4'b0001, 1'b1, 32'h104, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    chk("unst_flags", err_flags, 8'h10);
    chk("unst_code", first_err_code, 3'd4);
    chk("unst_addr", first_err_addr, 32'h104);
    chk("unst_errcnt", err_cnt, 4'd1);
    chk("unst_irq", irq, 1'b1);
    cyc(4'b0001, 1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    idle();
    clr = 1'b1;
    idle();
    chk("clr_flags", err_flags, 8'h00);
    chk("clr_xfer", xfer_cnt, 4'd0);
    chk("clr_valid", first_err_valid, 1'b0);

    // Multi-select with PENABLE on the setup cycle, then PSEL drop
    cyc(4'b0101, 1'b1, 32'h40, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    chk("multi_flags", err_flags, 8'h06);
    chk("multi_code", first_err_code, 3'd1);
    chk("multi_errcnt", err_cnt, 4'd1);
    cyc(4'b0000, 1'b0, 32'h40, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    chk("drop_flags", err_flags, 8'h0F);
    chk("drop_errcnt", err_cnt, 4'd2);
    chk("drop_code_kept", first_err_code, 3'd1);
    idle();
    chk("drop_no_cascade", err_cnt, 4'd2);
    clr = 1'b1;
    idle();

    // Watchdog: 20 wait cycles, flag after the 8th
    cyc(4'b0100, 1'b0, 32'h200, 1'b1, 4'hF, 32'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0100, 1'b1, 32'h200, 1'b1, 4'hF, 32'hDEAD, 1'b0, 1'b0);
      if (i == 6) chk("wd_before", err_flags, 8'h00);
      if (i == 7) chk("wd_at", err_flags, 8'h40);
    end
    chk("wd_flags", err_flags, 8'h40);
    chk("wd_errcnt", err_cnt, 4'd1);
    chk("wd_code", first_err_code, 3'd6);
    cyc(4'b0100, 1'b1, 32'h200, 1'b1, 4'hF, 32'hDEAD, 1'b1, 1'b0);
    chk("wd_xfer", xfer_cnt, 4'd1);
    idle();
    chk("wd_back_idle", err_cnt, 4'd1);

    // clr together with a read setup carrying PSTRB
    clr = 1'b1;
    cyc(4'b0001, 1'b0, 32'h300, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    chk("rdstrb_flags", err_flags, 8'h20);
    chk("rdstrb_errcnt", err_cnt, 4'd1);
    chk("rdstrb_valid", first_err_valid, 1'b1);
    chk("rdstrb_code", first_err_code, 3'd5);
    chk("rdstrb_addr", first_err_addr, 32'h300);
    chk("rdstrb_xfer", xfer_cnt, 4'd0);
    cyc(4'b0001, 1'b1, 32'h300, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    idle();
    clr = 1'b1;
    idle();

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      cyc(4'b1000, 1'b0, 32'(i * 4), 1'b1, 4'hF, 32'(i), 1'b0, 1'b0);
      cyc(4'b1000, 1'b1, 32'(i * 4), 1'b1, 4'hF, 32'(i), 1'b1, 1'b1);
    end
    idle();
    chk("sat_xfer", xfer_cnt, 4'd15);
    chk("sat_slverr", slverr_cnt, 4'd15);
    chk("sat_flags", err_flags, 8'h00);
    for (int i = 0; i < 18; i++) cyc(4'b0000, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    chk("sat_errcnt", err_cnt, 4'd15);
    chk("penidle_flags", err_flags, 8'h80);
    chk("penidle_code", first_err_code, 3'd7);

    // Reset mid-transfer
    cyc(4'b0001, 1'b0, 32'h500, 1'b1, 4'hF, 32'h1, 1'b0, 1'b0);
    PRESET = 1'b1;
    cyc(4'b0001, 1'b1, 32'h500, 1'b1, 4'hF, 32'h1, 1'b0, 1'b0);
    chk("mrst_flags", err_flags, 8'h00);
    chk("mrst_errcnt", err_cnt, 4'd0);
    chk("mrst_xfer", xfer_cnt, 4'd0);
    chk("mrst_slverr", slverr_cnt, 4'd0);
    chk("mrst_addr", first_err_addr, 32'h0);
    chk("mrst_irq", irq, 1'b0);
    PRESET = 1'b0;
    idle();
    chk("mrst_idle", err_flags, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
